// File: rtl/arb_pkg.sv
// Shared arbiter types and widths.
package arb_pkg;
    localparam int N_REQ = 4;
    localparam int ID_W  = 2;

    typedef enum logic {IDLE, GRANT} arb_state_t;
endpackage

// File: rtl/decoder2_4.sv
// 2:4 enabled decoder; all outputs low when en is low.
module decoder2_4 (
    input  logic [1:0] sel,
    input  logic       en,
    output logic [3:0] out
);
    assign out = en ? (4'b0001 << sel) : 4'b0000;
endmodule

// File: rtl/rr_arbiter4.sv
// Four-requester round-robin arbiter with sticky grants and an optional hold limit.
// Grant index is registered and decoded, so no output depends combinationally on req.
module rr_arbiter4
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic             gnt_valid,
    output logic [ID_W-1:0]  gnt_id
);
    localparam int CNT_W = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
    localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(MAX_HOLD);

    arb_state_t       state, state_nxt;
    logic [ID_W-1:0]  ptr, ptr_nxt;
    logic [ID_W-1:0]  gnt_id_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [ID_W-1:0]  winner;

    // First requester at or after the pointer, wrapping modulo 4.
    function automatic logic [ID_W-1:0] find_winner(input logic [N_REQ-1:0] r,
                                                    input logic [ID_W-1:0]  p);
        logic [ID_W-1:0] idx;
        logic            found;
        find_winner = p;
        found       = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = p + ID_W'(k);
            if (!found && r[idx]) begin
                find_winner = idx;
                found       = 1'b1;
            end
        end
    endfunction

    assign winner = find_winner(req, ptr);

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            ptr    <= '0;
            gnt_id <= '0;
            cnt    <= '0;
        end else begin
            state  <= state_nxt;
            ptr    <= ptr_nxt;
            gnt_id <= gnt_id_nxt;
            cnt    <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        ptr_nxt    = ptr;
        gnt_id_nxt = gnt_id;
        cnt_nxt    = cnt;
        case (state)
            IDLE: begin
                if (en && (|req)) begin
                    state_nxt  = GRANT;
                    gnt_id_nxt = winner;
                    cnt_nxt    = CNT_W'(1);
                end
            end
            GRANT: begin
                // Moving the pointer past the owner makes it lowest priority next round.
                if (!req[gnt_id] || ((MAX_HOLD != 0) && (cnt == HOLD_LIM))) begin
                    state_nxt = IDLE;
                    ptr_nxt   = gnt_id + ID_W'(1);
                end else if (MAX_HOLD != 0) begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign gnt_valid = (state == GRANT);

    decoder2_4 u_dec (
        .sel (gnt_id),
        .en  (gnt_valid),
        .out (gnt)
    );
endmodule

// File: tb/tb_rr_arbiter4.sv
// Directed bench for rr_arbiter4: one instance with MAX_HOLD=8, one with unlimited hold.
module tb_rr_arbiter4;
    logic       clk = 1'b0;
    logic       reset, en;
    logic [3:0] req;
    logic [3:0] gnt_a, gnt_b;
    logic       vld_a, vld_b;
    logic [1:0] id_a, id_b;

    int tests_run = 0;
    int failed    = 0;

    typedef struct {
        logic [3:0] gnt;
        logic       vld;
        logic [1:0] id;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    rr_arbiter4 #(.MAX_HOLD(8)) dut_a (
        .clk(clk), .reset(reset), .en(en), .req(req),
        .gnt(gnt_a), .gnt_valid(vld_a), .gnt_id(id_a)
    );

    rr_arbiter4 #(.MAX_HOLD(0)) dut_b (
        .clk(clk), .reset(reset), .en(en), .req(req),
        .gnt(gnt_b), .gnt_valid(vld_b), .gnt_id(id_b)
    );

    // Drive one cycle of inputs, queue the expected post-edge outputs, then check them.
    task automatic cyc(input string tag, input logic sel, input logic r, input logic e,
                       input logic [3:0] rq, input logic [3:0] eg, input logic [1:0] eid);
        exp_t x, y;
        logic [3:0] og;
        logic       ov;
        logic [1:0] oid;
        reset = r;
        en    = e;
        req   = rq;
        x.gnt = eg;
        x.vld = |eg;
        x.id  = eid;
        sb.push_back(x);
        @(posedge clk);
        #1;
        y   = sb.pop_front();
        og  = sel ? gnt_b : gnt_a;
        ov  = sel ? vld_b : vld_a;
        oid = sel ? id_b  : id_a;
        tests_run++;
        assert (og === y.gnt) else begin
            failed++;
            $error("FAIL %s gnt: got %b want %b", tag, og, y.gnt);
        end
        tests_run++;
        assert (ov === y.vld) else begin
            failed++;
            $error("FAIL %s gnt_valid: got %b want %b", tag, ov, y.vld);
        end
        tests_run++;
        assert (oid === y.id) else begin
            failed++;
            $error("FAIL %s gnt_id: got %0d want %0d", tag, oid, y.id);
        end
    endtask

    initial begin
        reset = 1'b1;
        en    = 1'b1;
        req   = 4'b0000;

        // Reset held with all requests high
        for (int i = 0; i < 3; i++) cyc("reset", 0, 1, 1, 4'b1111, 4'b0000, 2'd0);

        // Rotation: 8-cycle grants 0,1,2,3,0 with one-cycle gaps
        for (int k = 0; k < 5; k++) begin
            logic [1:0] w;
            w = 2'(k);
            for (int c = 0; c < 8; c++) cyc("rotate", 0, 0, 1, 4'b1111, 4'b0001 << w, w);
            cyc("rotate_gap", 0, 0, 1, 4'b1111, 4'b0000, w);
        end
        cyc("reset2", 0, 1, 1, 4'b1111, 4'b0000, 2'd0);

        // Early release: 2 drops after 3 cycles, 3 beats 0
        for (int c = 0; c < 3; c++) cyc("early_hold", 0, 0, 1, 4'b0100, 4'b0100, 2'd2);
        cyc("early_gap", 0, 0, 1, 4'b1001, 4'b0000, 2'd2);
        cyc("early_next", 0, 0, 1, 4'b1001, 4'b1000, 2'd3);
        cyc("early_rel", 0, 0, 1, 4'b0000, 4'b0000, 2'd3);
        cyc("idle_none", 0, 0, 1, 4'b0000, 4'b0000, 2'd3);

        // Enable gating
        cyc("en_block", 0, 0, 0, 4'b0100, 4'b0000, 2'd3);
        cyc("en_block", 0, 0, 0, 4'b0100, 4'b0000, 2'd3);
        cyc("en_grant", 0, 0, 1, 4'b0100, 4'b0100, 2'd2);
        cyc("en_keep", 0, 0, 0, 4'b0100, 4'b0100, 2'd2);
        cyc("en_keep", 0, 0, 0, 4'b0100, 4'b0100, 2'd2);
        cyc("en_rel", 0, 0, 0, 4'b0000, 4'b0000, 2'd2);

        // Reset mid-grant on requester 3 (ptr is 3 here), then ptr must be 0
        for (int c = 0; c < 3; c++) cyc("mid_hold", 0, 0, 1, 4'b1000, 4'b1000, 2'd3);
        cyc("mid_reset", 0, 1, 1, 4'b1000, 4'b0000, 2'd0);
        cyc("mid_after", 0, 0, 1, 4'b1001, 4'b0001, 2'd0);

        // Unlimited hold instance
        cyc("b_reset", 1, 1, 1, 4'b0000, 4'b0000, 2'd0);
        cyc("b_g0", 1, 0, 1, 4'b0001, 4'b0001, 2'd0);
        cyc("b_rel0", 1, 0, 1, 4'b0000, 4'b0000, 2'd0);
        for (int c = 0; c < 300; c++) cyc("b_hold", 1, 0, 1, 4'b0011, 4'b0010, 2'd1);
        cyc("b_gap", 1, 0, 1, 4'b0001, 4'b0000, 2'd1);
        cyc("b_next", 1, 0, 1, 4'b0001, 4'b0001, 2'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end
endmodule
